// File: rtl/stopwatch_lap_controller.sv
// stopwatch_lap_controller
//   Sequencer between the button debouncers and the stopwatch counter /
//   display formatter. It turns button levels into start/reset pulses for the
//   counter, captures lap times into a small buffer, and picks the time shown
//   on the display (live, frozen lap, or recalled lap).
//
//   Optional feature macro: SW_LAP_HOLD_TIMEOUT_EN
//     defined   : LAP_HOLD falls back to RUN after HOLD_MS tick_1ms rising edges
//     undefined : LAP_HOLD persists until a start or recall press
//
// Ports
//   i_clock        system clock
//   i_reset        asynchronous, active-high reset
//   i_btn_start    debounced start/stop level
//   i_btn_lap      debounced lap/clear level
//   i_btn_recall   debounced recall level
//   i_tick_1ms     1 ms level tick, rising edge detected internally
//   i_live_time    {hours[4:0],minutes[5:0],seconds[5:0],centiseconds[6:0]}
//   o_start_edge   1-cycle pulse: toggle counter run
//   o_reset_edge   1-cycle pulse: zero counter
//   o_disp_time    time to display, same packing as i_live_time
//   o_disp_mode    0 live, 1 lap hold, 2 recall
//   o_lap_index    entry shown in RECALL
//   o_lap_count    valid entries, 0..LAP_DEPTH
//   o_lap_full     lap_count == LAP_DEPTH
//   o_lap_overflow 1-cycle pulse: lap press dropped because buffer full
//
// State table
//   state    | meaning
//   S_IDLE   | counter zeroed and stopped, live time shown
//   S_RUN    | counter running, live time shown
//   S_LAP_HOLD | counter running, last captured lap frozen on display
//   S_PAUSED | counter stopped, live (frozen) time shown
//   S_RECALL | browsing stored laps, returns to IDLE or PAUSED on start

module stopwatch_lap_controller #(
  parameter int LAP_DEPTH = 8,
  parameter int IDX_W     = 3
`ifdef SW_LAP_HOLD_TIMEOUT_EN
  , parameter int HOLD_MS = 2000
`endif
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_btn_start,
  input  logic             i_btn_lap,
  input  logic             i_btn_recall,
  input  logic             i_tick_1ms,
  input  logic [23:0]      i_live_time,
  output logic             o_start_edge,
  output logic             o_reset_edge,
  output logic [23:0]      o_disp_time,
  output logic [1:0]       o_disp_mode,
  output logic [IDX_W-1:0] o_lap_index,
  output logic [IDX_W:0]   o_lap_count,
  output logic             o_lap_full,
  output logic             o_lap_overflow
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_LAP_HOLD = 3'd2,
    S_PAUSED   = 3'd3,
    S_RECALL   = 3'd4
  } state_t;

  localparam logic [IDX_W:0] LP_DEPTH = (IDX_W+1)'(LAP_DEPTH);
  localparam logic [IDX_W:0] LP_ONE   = (IDX_W+1)'(1);

  state_t           r_state;
  state_t           r_ret_state;
  logic             r_start_prev;
  logic             r_lap_prev;
  logic             r_recall_prev;
  logic             r_tick_prev;
  logic             r_start_edge;
  logic             r_reset_edge;
  logic             r_lap_overflow;
  logic [23:0]      r_disp_time;
  logic [1:0]       r_disp_mode;
  logic [IDX_W-1:0] r_lap_index;
  logic [IDX_W:0]   r_lap_count;
  logic [23:0]      r_held;
  logic [23:0]      r_buf [LAP_DEPTH];

  logic             w_start;
  logic             w_lap;
  logic             w_recall;
  logic             w_full;
  logic             w_has_laps;
  logic             w_capture;
  logic             w_write;
  logic             w_idx_last;
  logic [23:0]      w_disp_src;
  logic [1:0]       w_mode_src;

  // Priority start > lap > recall; lower-priority presses in the same cycle are dropped.
  assign w_start    = i_btn_start & ~r_start_prev;
  assign w_lap      = i_btn_lap & ~r_lap_prev & ~w_start;
  assign w_recall   = i_btn_recall & ~r_recall_prev & ~w_start & ~(i_btn_lap & ~r_lap_prev);

  assign w_full     = (r_lap_count == LP_DEPTH);
  assign w_has_laps = (r_lap_count != '0);
  assign w_capture  = w_lap & ((r_state == S_RUN) | (r_state == S_LAP_HOLD));
  assign w_write    = w_capture & ~w_full;
  assign w_idx_last = ({1'b0, r_lap_index} == (r_lap_count - LP_ONE));

`ifdef SW_LAP_HOLD_TIMEOUT_EN
  logic [15:0] r_hold_cnt;
  logic        w_tick_rise;
  logic        w_hold_done;

  assign w_tick_rise = i_tick_1ms & ~r_tick_prev;
  assign w_hold_done = (r_hold_cnt == 16'(HOLD_MS));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_hold_cnt <= '0;
    end else if (w_capture) begin
      r_hold_cnt <= '0;
    end else if ((r_state == S_LAP_HOLD) && w_tick_rise && !w_hold_done) begin
      r_hold_cnt <= r_hold_cnt + 16'd1;
    end
  end
`else
  logic w_hold_done;
  assign w_hold_done = 1'b0;
`endif

  // Lap storage carries no reset; entries beyond lap_count are never shown.
  always_ff @(posedge i_clock) begin
    if (w_write) begin
      r_buf[r_lap_count[IDX_W-1:0]] <= i_live_time;
    end
  end

  always_comb begin
    w_disp_src = i_live_time;
    w_mode_src = 2'd0;
    case (r_state)
      S_LAP_HOLD: begin
        w_disp_src = r_held;
        w_mode_src = 2'd1;
      end
      S_RECALL: begin
        w_disp_src = r_buf[r_lap_index];
        w_mode_src = 2'd2;
      end
      default: begin
        w_disp_src = i_live_time;
        w_mode_src = 2'd0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_ret_state    <= S_IDLE;
      r_start_prev   <= 1'b0;
      r_lap_prev     <= 1'b0;
      r_recall_prev  <= 1'b0;
      r_tick_prev    <= 1'b0;
      r_start_edge   <= 1'b0;
      r_reset_edge   <= 1'b0;
      r_lap_overflow <= 1'b0;
      r_disp_time    <= '0;
      r_disp_mode    <= 2'd0;
      r_lap_index    <= '0;
      r_lap_count    <= '0;
      r_held         <= '0;
    end else begin
      r_start_prev   <= i_btn_start;
      r_lap_prev     <= i_btn_lap;
      r_recall_prev  <= i_btn_recall;
      r_tick_prev    <= i_tick_1ms;
      r_start_edge   <= 1'b0;
      r_reset_edge   <= 1'b0;
      r_lap_overflow <= 1'b0;
      r_disp_time    <= w_disp_src;
      r_disp_mode    <= w_mode_src;

      if (w_capture) begin
        if (w_full) begin
          r_lap_overflow <= 1'b1;
        end else begin
          r_lap_count <= r_lap_count + LP_ONE;
          r_held      <= i_live_time;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_start_edge <= 1'b1;
            r_state      <= S_RUN;
          end else if (w_recall && w_has_laps) begin
            r_lap_index <= '0;
            r_ret_state <= S_IDLE;
            r_state     <= S_RECALL;
          end
        end
        S_RUN: begin
          if (w_start) begin
            r_start_edge <= 1'b1;
            r_state      <= S_PAUSED;
          end else if (w_lap) begin
            r_state <= S_LAP_HOLD;
          end
        end
        S_LAP_HOLD: begin
          if (w_start) begin
            r_start_edge <= 1'b1;
            r_state      <= S_PAUSED;
          end else if (w_lap) begin
            r_state <= S_LAP_HOLD;
          end else if (w_recall || w_hold_done) begin
            r_state <= S_RUN;
          end
        end
        S_PAUSED: begin
          if (w_start) begin
            r_start_edge <= 1'b1;
            r_state      <= S_RUN;
          end else if (w_lap) begin
            r_reset_edge <= 1'b1;
            r_lap_count  <= '0;
            r_state      <= S_IDLE;
          end else if (w_recall && w_has_laps) begin
            r_lap_index <= '0;
            r_ret_state <= S_PAUSED;
            r_state     <= S_RECALL;
          end
        end
        S_RECALL: begin
          if (w_start) begin
            r_state <= r_ret_state;
          end else if (w_lap) begin
            r_reset_edge <= 1'b1;
            r_lap_count  <= '0;
            r_state      <= S_IDLE;
          end else if (w_recall) begin
            r_lap_index <= w_idx_last ? '0 : r_lap_index + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_start_edge   = r_start_edge;
  assign o_reset_edge   = r_reset_edge;
  assign o_disp_time    = r_disp_time;
  assign o_disp_mode    = r_disp_mode;
  assign o_lap_index    = r_lap_index;
  assign o_lap_count    = r_lap_count;
  assign o_lap_full     = w_full;
  assign o_lap_overflow = r_lap_overflow;

endmodule
